// File: rtl/segapcm_bus_master.sv
// Host-side bus master for the SegaPCM CPU port: queues register commands in a
// small FIFO and plays them out as timed nSCS/nSRD/nSWR cycles, honouring nWAIT.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | bus released; pops the FIFO head when one is queued
// S_SETUP  | chip select and address (and write data) settle before strobe
// S_STROBE | read/write strobe low; stretched while synced nWAIT is low
// S_HOLD   | strobe released, select/address/data held one more cycle
module segapcm_bus_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_MIN   = 4,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [10:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_ERR,
  output logic        ERR,
  output logic        BUSY,
  output logic        nSCS,
  output logic        nSRD,
  output logic        nSWR,
  output logic [10:0] A,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic [7:0]  D_IN,
  input  logic        nWAIT
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  SC_LAST  = 8'(STROBE_MIN - 1);
  localparam logic [7:0]  WC_MAX   = 8'(WAIT_TIMEOUT);
  localparam logic [1:0]  SU_LAST  = 2'(SETUP_CYC - 1);

  state_t        state_q, state_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [19:0]   mem_q [FIFO_DEPTH];
  logic [19:0]   cmd_q, cmd_d;
  logic [1:0]    su_q, su_d;
  logic [7:0]    sc_q, sc_d, wc_q, wc_d;
  logic          abort_q, abort_d, err_q, err_d, ready_q, ready_d, w_s_q;
  logic          nscs_q, nscs_d, nsrd_q, nsrd_d, nswr_q, nswr_d;
  logic [10:0]   a_q, a_d;
  logic [7:0]    d_out_q, d_out_d, rsp_data_q, rsp_data_d;
  logic          d_oe_q, d_oe_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic          push, pop;
  logic          cmd_wr;
  logic [10:0]   cmd_addr;
  logic [7:0]    cmd_wdata;

  assign push      = CMD_VALID & ready_q;
  assign cmd_wr    = cmd_q[19];
  assign cmd_addr  = cmd_q[18:8];
  assign cmd_wdata = cmd_q[7:0];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    su_d    = su_q;
    sc_d    = sc_q;
    wc_d    = wc_q;
    abort_d = abort_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          su_d    = 2'd0;
          sc_d    = 8'd0;
          wc_d    = 8'd0;
          abort_d = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (su_q == SU_LAST) state_d = S_STROBE;
        else                 su_d    = su_q + 2'd1;
      end
      S_STROBE: begin
        if (sc_q < SC_LAST) begin
          sc_d = sc_q + 8'd1;
        end else if (w_s_q) begin
          state_d = S_HOLD;
        end else if (wc_q == WC_MAX) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          wc_d = wc_q + 8'd1;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins are registered from the current state, so they trail it by one cycle.
  always_comb begin
    nscs_d      = 1'b1;
    nsrd_d      = 1'b1;
    nswr_d      = 1'b1;
    a_d         = 11'd0;
    d_out_d     = 8'd0;
    d_oe_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    if (state_q != S_IDLE) begin
      nscs_d  = 1'b0;
      a_d     = cmd_addr;
      d_oe_d  = cmd_wr;
      d_out_d = cmd_wr ? cmd_wdata : 8'd0;
    end
    if (state_q == S_STROBE) begin
      nsrd_d = cmd_wr;
      nswr_d = ~cmd_wr;
    end
    // HOLD state coincides with the last strobe-low cycle on the pins.
    if (state_q == S_HOLD && !cmd_wr) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = abort_q;
      rsp_data_d  = abort_q ? 8'hFF : D_IN;
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {CMD_WR, CMD_ADDR, CMD_WDATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b0;
      cmd_q       <= '0;
      su_q        <= 2'd0;
      sc_q        <= 8'd0;
      wc_q        <= 8'd0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      w_s_q       <= 1'b1;
      nscs_q      <= 1'b1;
      nsrd_q      <= 1'b1;
      nswr_q      <= 1'b1;
      a_q         <= 11'd0;
      d_out_q     <= 8'd0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      cmd_q       <= cmd_d;
      su_q        <= su_d;
      sc_q        <= sc_d;
      wc_q        <= wc_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      w_s_q       <= nWAIT;
      nscs_q      <= nscs_d;
      nsrd_q      <= nsrd_d;
      nswr_q      <= nswr_d;
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign CMD_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign ERR       = err_q;
  assign BUSY      = (count_q != '0) | (state_q != S_IDLE);
  assign nSCS      = nscs_q;
  assign nSRD      = nsrd_q;
  assign nSWR      = nswr_q;
  assign A         = a_q;
  assign D_OUT     = d_out_q;
  assign D_OE      = d_oe_q;

endmodule
